irq_rr_arbiter_32: RTL and testbench

Interrupt request arbiter for the KGP miniRISC core.
- Captures rising edges on 32 interrupt lines into a pending register and applies a software mask.
- Selects one eligible request with round-robin priority and presents it as a registered one-hot grant with a valid/ack handshake.
- grant_onehot feeds the 32-to-5 one-hot encoder directly upstream of the interrupt-vector logic. grant_valid qualifies the encoded index, because the encoder also outputs 31 for an all-zero input.

---
 rtl/irq_rr_arbiter_32_pkg.sv | 7 +
 rtl/irq_rr_arbiter_32_rr_pick.sv | 23 ++
 rtl/irq_rr_arbiter_32.sv | 76 +++++++
 tb/tb_irq_rr_arbiter_32.sv | 117 +++++++++++
 4 files changed

// File: rtl/irq_rr_arbiter_32_pkg.sv
// irq_rr_arbiter_32_pkg: shared widths, mask reset value and FSM state encoding for the IRQ arbiter
package irq_rr_arbiter_32_pkg;
  localparam int IRQ_N = 32;
  localparam int IRQ_PTR_W = 5;
  localparam logic [IRQ_N-1:0] MASK_RST = 32'hFFFF_FFFF;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
endpackage

// File: rtl/irq_rr_arbiter_32_rr_pick.sv
// rr_pick_32: round-robin pick (eligible, ptr) -> one-hot pick and its index, via rotate/lowest-set/rotate-back
module rr_pick_32
  import irq_rr_arbiter_32_pkg::*;
(
  input  logic [IRQ_N-1:0]     eligible,
  input  logic [IRQ_PTR_W-1:0] ptr,
  output logic [IRQ_N-1:0]     pick_onehot,
  output logic [IRQ_PTR_W-1:0] pick_idx
);
  logic [IRQ_N-1:0]     w_rot;
  logic [IRQ_N-1:0]     w_lsb;
  logic [IRQ_PTR_W:0]   w_back;
  logic [IRQ_PTR_W-1:0] w_ridx;
  assign w_back      = 6'd32 - {1'b0, ptr};
  assign w_rot       = (eligible >> ptr) | (eligible << w_back);
  assign w_lsb       = w_rot & (~w_rot + 32'd1);
  assign pick_onehot = (w_lsb << ptr) | (w_lsb >> w_back);
  assign pick_idx    = w_ridx + ptr;
  always_comb begin
    w_ridx = '0;
    for (int i = IRQ_N - 1; i >= 0; i--) w_ridx = w_rot[i] ? IRQ_PTR_W'(i) : w_ridx;
  end
endmodule

// File: rtl/irq_rr_arbiter_32.sv
// irq_rr_arbiter_32: edge-captured, maskable 32-line IRQ arbiter with round-robin one-hot grant and valid/ack handshake
module irq_rr_arbiter_32
  import irq_rr_arbiter_32_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IRQ_N-1:0] irq_in,
  input  logic             mask_wr_en,
  input  logic [IRQ_N-1:0] mask_wr_data,
  output logic [IRQ_N-1:0] mask_out,
  output logic [IRQ_N-1:0] pending_out,
  output logic             grant_valid,
  output logic [IRQ_N-1:0] grant_onehot,
  input  logic             grant_ack
);
  logic [IRQ_N-1:0]     r_irq_q;
  logic [IRQ_N-1:0]     r_pending;
  logic [IRQ_N-1:0]     r_mask;
  logic [IRQ_PTR_W-1:0] r_ptr;
  logic [IRQ_PTR_W-1:0] r_gidx;
  logic [IRQ_N-1:0]     r_grant_onehot;
  logic                 r_grant_valid;
  state_t               r_state;
  logic [IRQ_N-1:0]     w_rise;
  logic [IRQ_N-1:0]     w_clr;
  logic [IRQ_N-1:0]     w_eligible;
  logic [IRQ_N-1:0]     w_pick;
  logic [IRQ_PTR_W-1:0] w_pick_idx;
  logic                 w_ack;
  assign w_rise       = irq_in & ~r_irq_q;
  assign w_ack        = (r_state == ST_GRANT) && grant_ack;
  assign w_clr        = w_ack ? r_grant_onehot : '0;
  assign w_eligible   = r_pending & ~r_mask;
  assign mask_out     = r_mask;
  assign pending_out  = r_pending;
  assign grant_valid  = r_grant_valid;
  assign grant_onehot = r_grant_onehot;
  rr_pick_32 u_pick (
    .eligible    (w_eligible),
    .ptr         (r_ptr),
    .pick_onehot (w_pick),
    .pick_idx    (w_pick_idx)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_q   <= '0;
      r_pending <= '0;
      r_mask    <= MASK_RST;
    end else begin
      r_irq_q   <= irq_in;
      r_pending <= (r_pending & ~w_clr) | w_rise;
      r_mask    <= mask_wr_en ? mask_wr_data : r_mask;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_ptr          <= '0;
      r_gidx         <= '0;
      r_grant_valid  <= 1'b0;
      r_grant_onehot <= '0;
    end else if (r_state == ST_IDLE) begin
      if (|w_eligible) begin
        r_grant_onehot <= w_pick;
        r_gidx         <= w_pick_idx;
        r_grant_valid  <= 1'b1;
        r_state        <= ST_GRANT;
      end
    end else if (grant_ack) begin
      r_ptr          <= r_gidx + 1'b1;
      r_grant_valid  <= 1'b0;
      r_grant_onehot <= '0;
      r_state        <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_irq_rr_arbiter_32.sv
// tb_irq_rr_arbiter_32: randomized self-checking bench against a behavioural model of the IRQ arbiter
module tb_irq_rr_arbiter_32;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] irq_in = '0;
  logic        mask_wr_en = 1'b0;
  logic [31:0] mask_wr_data = '0;
  logic [31:0] mask_out;
  logic [31:0] pending_out;
  logic        grant_valid;
  logic [31:0] grant_onehot;
  logic        grant_ack = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  bit [31:0] m_irq_q, m_pending, m_mask;
  int m_ptr, m_gidx;
  bit m_gv;
  irq_rr_arbiter_32 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .irq_in       (irq_in),
    .mask_wr_en   (mask_wr_en),
    .mask_wr_data (mask_wr_data),
    .mask_out     (mask_out),
    .pending_out  (pending_out),
    .grant_valid  (grant_valid),
    .grant_onehot (grant_onehot),
    .grant_ack    (grant_ack)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int first_eligible(input bit [31:0] elig, input int ptr);
    for (int i = 0; i < 32; i++) if (elig[(ptr + i) % 32]) return (ptr + i) % 32;
    return -1;
  endfunction
  task automatic model_reset();
    m_irq_q = '0; m_pending = '0; m_mask = 32'hFFFF_FFFF; m_ptr = 0; m_gidx = 0; m_gv = 0;
  endtask
  task automatic model_edge();
    bit [31:0] rise, clr, elig;
    int w;
    rise = irq_in & ~m_irq_q;
    clr = (m_gv && grant_ack) ? (32'd1 << m_gidx) : 32'd0;
    elig = m_pending & ~m_mask;
    if (!m_gv) begin
      w = first_eligible(elig, m_ptr);
      if (w >= 0) begin m_gv = 1; m_gidx = w; end
    end else if (grant_ack) begin
      m_gv = 0;
      m_ptr = (m_gidx + 1) % 32;
    end
    m_pending = (m_pending & ~clr) | rise;
    if (mask_wr_en) m_mask = mask_wr_data;
    m_irq_q = irq_in;
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".valid"}, {31'd0, grant_valid}, {31'd0, m_gv});
    chk({tag, ".grant"}, grant_onehot, m_gv ? (32'd1 << m_gidx) : 32'd0);
    chk({tag, ".pending"}, pending_out, m_pending);
    chk({tag, ".mask"}, mask_out, m_mask);
    chk({tag, ".onehot0"}, {31'd0, $onehot0(grant_onehot)}, 32'd1);
  endtask
  task automatic step(input string tag, input logic [31:0] irq, input logic we, input logic [31:0] wd, input logic ack);
    irq_in = irq; mask_wr_en = we; mask_wr_data = wd; grant_ack = ack;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask
  initial begin
    logic [31:0] irq, wd;
    int budget;
    model_reset();
    irq_in = 32'h8;
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("held_masked", 32'h8, 0, 0, 0);
    step("held_masked2", 32'h8, 0, 0, 0);
    step("unmask", 32'h8, 1, 32'h0, 0);
    step("grant3", 32'h8, 0, 0, 0);
    step("ack3", 32'h8, 0, 0, 1);
    step("rise5", 32'h28, 0, 0, 0);
    step("grant5", 32'h28, 0, 0, 0);
    step("ack5_rise4", 32'h38, 0, 0, 1);
    irq = 32'h38;
    for (int c = 0; c < 3000; c++) begin
      irq ^= $urandom & $urandom & $urandom;
      wd = ($urandom % 3 == 0) ? 32'h0 : ($urandom % 2 ? $urandom : ($urandom & $urandom));
      step("rand", irq, ($urandom % 16) == 0, wd, ($urandom % 3) == 0);
    end
    step("unmask_all", irq, 1, 32'h0, 0);
    budget = 0;
    while (!m_gv && budget < 40) begin
      irq ^= 32'h1 << ($urandom % 32);
      step("seek", irq, 0, 0, 0);
      budget++;
    end
    chk("seek_grant", {31'd0, grant_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async.valid", {31'd0, grant_valid}, 32'd0);
    chk("async.grant", grant_onehot, 32'd0);
    chk("async.pending", pending_out, 32'd0);
    chk("async.mask", mask_out, 32'hFFFF_FFFF);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
